// File: rtl/cache_32x4.sv
// cache_32x4: single-port word memory with byte-strobed writes and a one-cycle registered read.
module cache_32x4 #(
  parameter int base_addresse = 0,
  parameter int size = 2048,
  parameter int xlen = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [xlen-1:0] adr,
  input  logic [xlen-1:0] data,
  input  logic [3:0]      strobe,
  output logic [xlen-1:0] resp,
  output logic            ack
);
  localparam int AW = size > 1 ? $clog2(size) : 1;
  localparam logic [xlen-1:0] BASE = xlen'(base_addresse);
  localparam logic [xlen-1:0] SIZE = xlen'(size);
  logic [xlen-1:0] mem [size];
  logic [xlen-1:0] w_idx;
  logic            w_in;
  assign w_idx = (adr - BASE) >> 2;
  assign w_in  = (adr >= BASE) && (w_idx < SIZE);
  // No reset on the array: contents survive reset and are preloaded from outside.
  always_ff @(posedge clk)
    if (!rst_n && w_v && w_in)
      for (int k = 0; k < 4; k++)
        if (strobe[k]) mem[w_idx[AW-1:0]][8*k+:8] <= data[8*k+:8];
  // Nonblocking read of mem gives read-before-write on a simultaneous access.
  always_ff @(posedge clk)
    if (rst_n) begin
      resp <= '0;
      ack  <= 1'b0;
    end else begin
      ack <= r_v | w_v;
      if (r_v) resp <= w_in ? mem[w_idx[AW-1:0]] : '0;
    end
endmodule

// File: tb/tb_cache_32x4.sv
// tb_cache_32x4: directed and randomized checks of an instruction and a data instance against an array model.
module tb_cache_32x4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst;
  logic        i_rv, i_wv, d_rv, d_wv;
  logic [31:0] i_adr, i_data, d_adr, d_data, i_resp, d_resp;
  logic [3:0]  i_st, d_st;
  logic        i_ack, d_ack;
  int tests = 0, fails = 0;
  logic [31:0] model [2048];
  logic [31:0] exp_resp;
  logic        exp_ack;

  cache_32x4 #(.base_addresse(10000)) imem (
    .clk(clk), .rst_n(rst), .r_v(i_rv), .w_v(i_wv), .adr(i_adr), .data(i_data),
    .strobe(i_st), .resp(i_resp), .ack(i_ack));
  cache_32x4 #(.base_addresse(20000)) dmem (
    .clk(clk), .rst_n(rst), .r_v(d_rv), .w_v(d_wv), .adr(d_adr), .data(d_data),
    .strobe(d_st), .resp(d_resp), .ack(d_ack));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    longint off = longint'(a) - 20000;
    return off >= 0 && off / 4 < 2048;
  endfunction

  // One dmem request at an edge; model updates and both outputs are checked just after.
  task automatic dreq(input logic r, input logic rv, input logic wv, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input string tag);
    int idx;
    @(negedge clk);
    rst = r; d_rv = rv; d_wv = wv; d_adr = a; d_data = d; d_st = s;
    @(posedge clk);
    idx = int'((longint'(a) - 20000) / 4);
    if (r) begin
      exp_resp = 0;
      exp_ack = 0;
    end else begin
      exp_ack = rv | wv;
      if (rv) exp_resp = in_rng(a) ? model[idx] : 32'h0;
      if (wv && in_rng(a))
        for (int k = 0; k < 4; k++)
          if (s[k]) model[idx][8*k+:8] = d[8*k+:8];
    end
    #1;
    chk({tag, "_ack"}, {31'b0, d_ack}, {31'b0, exp_ack});
    chk({tag, "_resp"}, d_resp, exp_resp);
  endtask

  task automatic mem_cmp(input string tag);
    int diffs = 0;
    for (int i = 0; i < 2048; i++) if (dmem.mem[i] !== model[i]) diffs++;
    chk(tag, diffs, 0);
  endtask

  initial begin
    rst = 1; i_rv = 0; i_wv = 0; i_adr = 0; i_data = 0; i_st = 0;
    d_rv = 0; d_wv = 0; d_adr = 0; d_data = 0; d_st = 0;
    for (int i = 0; i < 2048; i++) begin
      model[i] = $urandom;
      imem.mem[i] = $urandom;
    end
    model[1] = 32'h11223344;
    model[2] = 32'h12345678;
    for (int i = 0; i < 2048; i++) dmem.mem[i] = model[i];
    imem.mem[0] = 32'h00500093;
    imem.mem[3] = 32'hDEADBEEF;
    exp_resp = 0;
    exp_ack = 0;
    // Reset with a pending read and write: both dropped.
    dreq(1, 1, 1, 20000, 32'hCAFEF00D, 4'hF, "rst0");
    dreq(1, 1, 0, 20000, 0, 0, "rst1");
    chk("rst_mem0", dmem.mem[0], model[0]);
    dreq(0, 1, 0, 20000, 0, 0, "rel");
    // Instruction memory reads.
    @(negedge clk); d_rv = 0; i_rv = 1; i_adr = 10000;
    @(negedge clk); chk("i0_resp", i_resp, 32'h00500093); chk("i0_ack", {31'b0, i_ack}, 1);
    i_adr = 10012;
    @(negedge clk); chk("i3_resp", i_resp, 32'hDEADBEEF); chk("i3_ack", {31'b0, i_ack}, 1);
    i_rv = 0;
    @(negedge clk); chk("i_idle_ack", {31'b0, i_ack}, 0); chk("i_idle_resp", i_resp, 32'hDEADBEEF);
    exp_ack = 0;
    // Byte strobes.
    dreq(0, 0, 1, 20004, 32'hAABBCCDD, 4'b0101, "wr5");
    dreq(0, 1, 0, 20004, 0, 0, "rd5");
    chk("strobe5", d_resp, 32'h11BB33DD);
    dreq(0, 0, 1, 20004, 32'hAABBCCDD, 4'b1111, "wrF");
    dreq(0, 1, 0, 20004, 0, 0, "rdF");
    chk("strobeF", d_resp, 32'hAABBCCDD);
    // Read and write on the same edge.
    dreq(0, 1, 1, 20008, 32'h0, 4'hF, "rw");
    chk("rw_old", d_resp, 32'h12345678);
    dreq(0, 1, 0, 20008, 0, 0, "rw_after");
    chk("rw_new", d_resp, 32'h0);
    // Out of range and zero strobe.
    dreq(0, 0, 1, 0, 32'hFFFFFFFF, 4'hF, "oor_wr");
    dreq(0, 0, 1, 20012, 32'hFFFFFFFF, 4'h0, "zero_st");
    mem_cmp("oor_mem");
    dreq(0, 1, 0, 20000 + 4 * 2048, 0, 0, "oor_rd");
    chk("oor_rd0", d_resp, 32'h0);
    // Idle with X address, then misaligned read.
    dreq(0, 0, 0, 32'hxxxxxxxx, 32'hxxxxxxxx, 4'hx, "idle");
    mem_cmp("idle_mem");
    dreq(0, 1, 0, 20005, 0, 0, "misal");
    chk("misal_val", d_resp, 32'hAABBCCDD);
    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'(20000 + $urandom_range(0, 8300));
      dreq($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), a, $urandom, 4'($urandom), "rnd");
    end
    mem_cmp("final_mem");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_32x4.md
Name: cache_32x4

Overview:
- Single-port, word-organised synchronous memory: 32-bit words, 4 byte lanes, byte-strobed writes.
- Used twice in the CPU system: once as instruction memory (read-only in use) and once as data memory (load/store port).
- Maps a contiguous byte-address window starting at base_addresse onto an internal word array.
- The array is preloaded by the bench through the hierarchical name "mem".

Parameters:
- base_addresse, 0: byte address of word 0 (decimal integer; the system uses 10000 for instructions and 20000 for data).
- size, 2048: number of words in the array.
- xlen, 32: word width in bits; must be 32 (4 byte lanes).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; keeps the codebase name but is active-high (1 = reset asserted).
- r_v  input  1  read request valid.
- w_v  input  1  write request valid.
- adr  input  xlen  byte address of the request.
- data  input  xlen  write data.
- strobe  input  4  byte-lane write enables; bit k covers data[8k+7:8k].
- resp  output  xlen  read data.
- ack  output  1  request completed, one cycle after the request.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Storage:
  - Internal array "mem" of size words, each xlen bits, word-indexed 0..size-1.
  - Must be accessible hierarchically (inst.mem[i]) for backdoor preload at time 0.
  - Contents are NOT cleared by reset.
- Address decode:
  - offset = adr - base_addresse, unsigned xlen-bit arithmetic.
  - Index = offset >> 2; adr[1:0] ignored (no misalignment handling; access always whole-word aligned).
  - In range iff adr >= base_addresse and index < size; otherwise out of range.
- Read:
  - r_v=1 at edge N with in-range adr: resp = mem[index] and ack=1 during cycle N+1 (1-cycle registered latency).
  - Out-of-range read: resp=0, ack=1.
- Write:
  - w_v=1 at edge N with in-range adr: each lane k with strobe[k]=1 takes data byte k into mem[index] at edge N; lanes with strobe[k]=0 unchanged.
  - ack=1 in cycle N+1.
  - Out-of-range write: no array change, ack=1.
  - strobe=0 with w_v=1: no change, ack still 1.
- Simultaneous r_v and w_v at the same edge:
  - Write performed as above.
  - resp returns pre-write contents (read-before-write).
  - Single ack.
- No request (r_v=0, w_v=0): ack=0 next cycle; resp holds its last value.
- Back-to-back requests every cycle are accepted; no stall, no backpressure.
- r_v tied to 1 is legal: continuous streaming reads, each returning the word for the address presented one cycle earlier.
- Reset (rst_n=1 at an edge):
  - resp=0 and ack=0 from the next cycle.
  - Any request presented in the same cycle is dropped: no write, no ack.
  - Reset mid-stream aborts the pending response only.
- Unknown/X on adr while r_v=0 and w_v=0 must not corrupt mem.

Test Plan:
- Reset: hold rst_n=1 for 2 cycles with r_v=1, adr=base → resp=0, ack=0; release → next cycle resp=mem[0], ack=1.
- Preload and read (base_addresse=10000): mem[0]=32'h00500093, mem[3]=32'hDEADBEEF; read adr=10000 then 10012 on consecutive cycles → resp 00500093 then DEADBEEF, each one cycle after its address, ack high both cycles.
- Byte-strobe write (base 20000): mem[1]=32'h11223344; write adr=20004, data=AABBCCDD, strobe=4'b0101 → read back 11BB33DD; strobe=4'b1111 → AABBCCDD.
- Read/write same edge: mem[2]=32'h12345678; r_v=w_v=1, adr=20008, data=0, strobe=F → resp=12345678; following read → 0.
- Out of range: base=20000, write adr=0 with data=FFFFFFFF, strobe=F → ack=1, no word changes; read adr=20000+4*2048 → resp=0, ack=1.
- Idle and misaligned: r_v=w_v=0 → ack=0, resp holds; read adr=20005 → returns mem[1].
